// File: rtl/spi_ram_burst.sv
// Command-driven RAM behind an SPI slave: address set, write, and read commands.
// Burst auto-increment, tx backpressure and sticky error flags are included.
module spi_ram_burst #(
    parameter int WORD_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(MEM_DEPTH),
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [WORD_W+1:0] din,
    input  logic              tx_ready,
    input  logic              err_clr,
    output logic [WORD_W-1:0] dout,
    output logic              tx_valid,
    output logic              err_ovf,
    output logic              err_addr
);

    localparam logic [1:0] CMD_SET_WR = 2'b00;
    localparam logic [1:0] CMD_WRITE  = 2'b01;
    localparam logic [1:0] CMD_SET_RD = 2'b10;
    localparam logic [1:0] CMD_READ   = 2'b11;

    logic [WORD_W-1:0] r_mem [MEM_DEPTH];
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [WORD_W-1:0] r_dout;
    logic              r_tx_valid;
    logic              r_err_ovf;
    logic              r_err_addr;

    logic [1:0]        w_cmd;
    logic [WORD_W-1:0] w_payload;
    logic [ADDR_W-1:0] w_payload_addr;
    logic              w_in_range;
    logic              w_set_wr;
    logic              w_set_rd;
    logic              w_write;
    logic              w_read_req;
    logic              w_rd_accept;
    logic              w_ovf_evt;
    logic              w_addr_evt;

    // Wrap at MEM_DEPTH-1 rather than at the power-of-two boundary.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(MEM_DEPTH - 1))
            return '0;
        return a + 1'b1;
    endfunction

    assign w_cmd          = din[WORD_W+1:WORD_W];
    assign w_payload      = din[WORD_W-1:0];
    assign w_payload_addr = w_payload[ADDR_W-1:0];
    assign w_in_range     = (32'(w_payload) < 32'(MEM_DEPTH));

    assign w_set_wr    = rx_valid && (w_cmd == CMD_SET_WR);
    assign w_write     = rx_valid && (w_cmd == CMD_WRITE);
    assign w_set_rd    = rx_valid && (w_cmd == CMD_SET_RD);
    assign w_read_req  = rx_valid && (w_cmd == CMD_READ);
    assign w_rd_accept = w_read_req && (!r_tx_valid || tx_ready);
    assign w_ovf_evt   = w_read_req && !w_rd_accept;
    assign w_addr_evt  = (w_set_wr || w_set_rd) && !w_in_range;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[r_wr_addr] <= w_payload;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_dout     <= '0;
            r_tx_valid <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_addr <= 1'b0;
        end else begin
            if (w_set_wr && w_in_range)
                r_wr_addr <= w_payload_addr;
            else if (w_write && (AUTO_INC != 0))
                r_wr_addr <= next_addr(r_wr_addr);

            if (w_set_rd && w_in_range)
                r_rd_addr <= w_payload_addr;
            else if (w_rd_accept && (AUTO_INC != 0))
                r_rd_addr <= next_addr(r_rd_addr);

            // An accepted read in the transfer cycle keeps tx_valid high back-to-back.
            if (w_rd_accept) begin
                r_dout     <= r_mem[r_rd_addr];
                r_tx_valid <= 1'b1;
            end else if (r_tx_valid && tx_ready) begin
                r_tx_valid <= 1'b0;
            end

            r_err_ovf  <= (r_err_ovf  && !err_clr) || w_ovf_evt;
            r_err_addr <= (r_err_addr && !err_clr) || w_addr_evt;
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign err_ovf  = r_err_ovf;
    assign err_addr = r_err_addr;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: 200-word instances with and without auto-increment
// share one command stream; expected values are written out by hand per step.
module tb_spi_ram_burst;

    localparam int WORD_W    = 8;
    localparam int MEM_DEPTH = 200;
    localparam int ADDR_W    = 8;

    localparam logic [1:0] SET_WR = 2'b00;
    localparam logic [1:0] WRITE  = 2'b01;
    localparam logic [1:0] SET_RD = 2'b10;
    localparam logic [1:0] READ   = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid;
    logic [WORD_W+1:0] din;
    logic              tx_ready;
    logic              err_clr;

    logic [WORD_W-1:0] dout, n_dout;
    logic              tx_valid, n_tx_valid;
    logic              err_ovf, n_err_ovf;
    logic              err_addr, n_err_addr;

    int n_cmp = 0;
    int n_err = 0;

    spi_ram_burst #(.WORD_W(WORD_W), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .AUTO_INC(1)) u_inc (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .tx_ready(tx_ready),
        .err_clr(err_clr), .dout(dout), .tx_valid(tx_valid), .err_ovf(err_ovf), .err_addr(err_addr)
    );

    spi_ram_burst #(.WORD_W(WORD_W), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .AUTO_INC(0)) u_noinc (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din), .tx_ready(tx_ready),
        .err_clr(err_clr), .dout(n_dout), .tx_valid(n_tx_valid), .err_ovf(n_err_ovf),
        .err_addr(n_err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] c, input logic [7:0] p, input logic rdy, input logic clr);
        rx_valid = 1'b1;
        din      = {c, p};
        tx_ready = rdy;
        err_clr  = clr;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic idle(input logic rdy, input logic clr);
        rx_valid = 1'b0;
        tx_ready = rdy;
        err_clr  = clr;
        @(posedge clk);
        #1;
        err_clr  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        din      = '0;
        tx_ready = 1'b0;
        err_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_txv", 32'(tx_valid), 32'h0);
        chk("rst_errs", {30'd0, err_ovf, err_addr}, 32'h0);
        chk("rst_noinc_txv", 32'(n_tx_valid), 32'h0);
        rst_n = 1'b1;

        // Reset while a read is stalled on the tx side
        cmd(SET_WR, 8'h03, 1'b0, 1'b0);
        cmd(WRITE,  8'h77, 1'b0, 1'b0);
        cmd(SET_RD, 8'h03, 1'b0, 1'b0);
        cmd(READ,   8'h00, 1'b0, 1'b0);
        chk("pend_txv", 32'(tx_valid), 32'h1);
        chk("pend_dout", 32'(dout), 32'h77);
        rst_n    = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst2_dout", 32'(dout), 32'h0);
        chk("rst2_txv", 32'(tx_valid), 32'h0);
        cmd(WRITE, 8'h5A, 1'b0, 1'b0);
        cmd(READ,  8'h00, 1'b0, 1'b0);
        chk("rst_addr0_dout", 32'(dout), 32'h5A);
        idle(1'b1, 1'b0);
        chk("rst_addr0_drain", 32'(tx_valid), 32'h0);

        // Burst write then back-to-back burst read
        cmd(SET_WR, 8'h10, 1'b1, 1'b0);
        cmd(WRITE,  8'hA1, 1'b1, 1'b0);
        cmd(WRITE,  8'hA2, 1'b1, 1'b0);
        cmd(WRITE,  8'hA3, 1'b1, 1'b0);
        cmd(SET_RD, 8'h10, 1'b1, 1'b0);
        cmd(READ,   8'h00, 1'b1, 1'b0);
        chk("burst_rd0", {23'd0, tx_valid, dout}, {23'd0, 1'b1, 8'hA1});
        cmd(READ,   8'h00, 1'b1, 1'b0);
        chk("burst_rd1", {23'd0, tx_valid, dout}, {23'd0, 1'b1, 8'hA2});
        cmd(READ,   8'h00, 1'b1, 1'b0);
        chk("burst_rd2", {23'd0, tx_valid, dout}, {23'd0, 1'b1, 8'hA3});
        idle(1'b1, 1'b0);
        chk("burst_end_txv", 32'(tx_valid), 32'h0);

        // Address wrap at MEM_DEPTH-1
        cmd(SET_WR, 8'd199, 1'b1, 1'b0);
        cmd(WRITE,  8'h55,  1'b1, 1'b0);
        cmd(WRITE,  8'h66,  1'b1, 1'b0);
        cmd(SET_RD, 8'd199, 1'b1, 1'b0);
        cmd(READ,   8'h00,  1'b1, 1'b0);
        chk("wrap_mem199", 32'(dout), 32'h55);
        cmd(READ,   8'h00,  1'b1, 1'b0);
        chk("wrap_mem0", 32'(dout), 32'h66);
        idle(1'b1, 1'b0);

        // Backpressure: second read dropped, first held stable
        cmd(SET_WR, 8'h20, 1'b0, 1'b0);
        cmd(WRITE,  8'hB1, 1'b0, 1'b0);
        cmd(WRITE,  8'hB2, 1'b0, 1'b0);
        cmd(SET_RD, 8'h20, 1'b0, 1'b0);
        cmd(READ,   8'h00, 1'b0, 1'b0);
        chk("bp_first", {22'd0, err_ovf, tx_valid, dout}, {22'd0, 1'b0, 1'b1, 8'hB1});
        cmd(READ,   8'h00, 1'b0, 1'b0);
        chk("bp_drop", {22'd0, err_ovf, tx_valid, dout}, {22'd0, 1'b1, 1'b1, 8'hB1});
        idle(1'b0, 1'b0);
        chk("bp_hold", {23'd0, tx_valid, dout}, {23'd0, 1'b1, 8'hB1});
        idle(1'b1, 1'b0);
        chk("bp_release_txv", 32'(tx_valid), 32'h0);
        cmd(READ,   8'h00, 1'b1, 1'b0);
        chk("bp_rdaddr_once", 32'(dout), 32'hB2);
        idle(1'b1, 1'b0);

        // Range errors and clear priority
        idle(1'b1, 1'b1);
        chk("clr_ovf", 32'(err_ovf), 32'h0);
        cmd(SET_RD, 8'h20, 1'b1, 1'b0);
        cmd(SET_RD, 8'd250, 1'b1, 1'b0);
        chk("range_err", 32'(err_addr), 32'h1);
        cmd(READ,   8'h00, 1'b1, 1'b0);
        chk("range_rdaddr_kept", 32'(dout), 32'hB1);
        idle(1'b1, 1'b1);
        chk("clr_addr", {30'd0, err_ovf, err_addr}, 32'h0);
        cmd(SET_WR, 8'd250, 1'b1, 1'b1);
        chk("clr_vs_addr_err", 32'(err_addr), 32'h1);
        cmd(READ,   8'h00, 1'b0, 1'b0);
        chk("ovf_setup", {23'd0, tx_valid, dout}, {23'd0, 1'b1, 8'hB2});
        cmd(READ,   8'h00, 1'b0, 1'b1);
        chk("clr_vs_ovf_err", {30'd0, err_ovf, err_addr}, {30'd0, 1'b1, 1'b0});
        idle(1'b1, 1'b0);

        // Address hold without auto-increment
        cmd(SET_WR, 8'h05, 1'b1, 1'b0);
        cmd(WRITE,  8'h11, 1'b1, 1'b0);
        cmd(WRITE,  8'h22, 1'b1, 1'b0);
        cmd(SET_RD, 8'h05, 1'b1, 1'b0);
        cmd(READ,   8'h00, 1'b1, 1'b0);
        chk("noinc_rd0", {23'd0, n_tx_valid, n_dout}, {23'd0, 1'b1, 8'h22});
        chk("inc_rd0", 32'(dout), 32'h11);
        cmd(READ,   8'h00, 1'b1, 1'b0);
        chk("noinc_rd1", {23'd0, n_tx_valid, n_dout}, {23'd0, 1'b1, 8'h22});
        chk("inc_rd1", 32'(dout), 32'h22);
        idle(1'b1, 1'b0);
        chk("noinc_end_txv", 32'(n_tx_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
